// File: rtl/dial_sum_pkg.sv
// Shared types and helpers for the dial/hex datapath controller.
// DIAL_SATURATE_EN selects saturating instead of wrapping dial positions.
package dial_sum_pkg;

  localparam int POS_W = 8;

  typedef enum logic [1:0] {
    MODE_SUM   = 2'd0,
    MODE_DIFF  = 2'd1,
    MODE_LEFT  = 2'd2,
    MODE_RIGHT = 2'd3
  } mode_t;

  // Opposing steps in the same cycle cancel out.
  function automatic logic [POS_W-1:0] pos_step(input logic [POS_W-1:0] pos,
                                                input logic up, input logic dn);
    logic [POS_W-1:0] w_nxt;
    w_nxt = pos;
    if (up && !dn) begin
`ifdef DIAL_SATURATE_EN
      if (pos != '1) w_nxt = pos + POS_W'(1);
`else
      w_nxt = pos + POS_W'(1);
`endif
    end else if (dn && !up) begin
`ifdef DIAL_SATURATE_EN
      if (pos != '0) w_nxt = pos - POS_W'(1);
`else
      w_nxt = pos - POS_W'(1);
`endif
    end
    return w_nxt;
  endfunction

  function automatic mode_t next_mode(input mode_t m);
    return mode_t'(m + 2'd1);
  endfunction

endpackage

// File: rtl/dial_sum_ctl_debounce.sv
// Click debouncer: accepts a level change after DEBOUNCE_CYCLES stable cycles
// and pulses press_evt for one cycle when the accepted state becomes pressed.
module click_debounce
  import dial_sum_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_n,
  output logic pressed,
  output logic press_evt
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_state;
  logic             r_evt;
  logic             w_differ;

  assign w_differ = (~raw_n) != r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_state <= 1'b0;
      r_evt   <= 1'b0;
    end else begin
      r_evt <= 1'b0;
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt   <= '0;
        r_state <= ~r_state;
        r_evt   <= ~r_state;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign pressed   = r_state;
  assign press_evt = r_evt;

endmodule

// File: rtl/dial_sum_ctl.sv
// Dial position tracking, click-driven mode FSM and registered hex display value.
// Build option: DIAL_SATURATE_EN (saturating positions instead of wrapping).
module dial_sum_ctl
  import dial_sum_pkg::*;
#(
  parameter int               DEBOUNCE_CYCLES = 500000,
  parameter logic [POS_W-1:0] POS_RESET       = 8'h00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rot_l_cw,
  input  logic             rot_l_ccw,
  input  logic             rot_r_cw,
  input  logic             rot_r_ccw,
  input  logic             click_l_n,
  input  logic             click_r_n,
  output logic [POS_W-1:0] pos_l,
  output logic [POS_W-1:0] pos_r,
  output logic [POS_W-1:0] disp_val,
  output logic [1:0]       disp_mode,
  output logic             disp_ovf,
  output logic [1:0]       click_evt
);

  logic [POS_W-1:0] r_pos_l;
  logic [POS_W-1:0] r_pos_r;
  logic [POS_W-1:0] r_disp;
  logic             r_ovf;
  mode_t            r_mode;
  logic [1:0]       w_evt;
  logic [1:0]       w_unused_pressed;
  logic [POS_W:0]   w_sum;
  logic [POS_W:0]   w_diff;

  click_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_l (
    .clk       (clk),
    .rst       (rst),
    .raw_n     (click_l_n),
    .pressed   (w_unused_pressed[0]),
    .press_evt (w_evt[0])
  );

  click_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_r (
    .clk       (clk),
    .rst       (rst),
    .raw_n     (click_r_n),
    .pressed   (w_unused_pressed[1]),
    .press_evt (w_evt[1])
  );

  // Left click clears both dials and overrides any rotary step that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pos_l <= POS_RESET;
      r_pos_r <= POS_RESET;
    end else if (w_evt[0]) begin
      r_pos_l <= POS_RESET;
      r_pos_r <= POS_RESET;
    end else begin
      r_pos_l <= pos_step(r_pos_l, rot_l_cw, rot_l_ccw);
      r_pos_r <= pos_step(r_pos_r, rot_r_cw, rot_r_ccw);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode <= MODE_SUM;
    end else if (w_evt[1]) begin
      r_mode <= next_mode(r_mode);
    end
  end

  assign w_sum  = {1'b0, r_pos_l} + {1'b0, r_pos_r};
  assign w_diff = {1'b0, r_pos_l} - {1'b0, r_pos_r};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_disp <= '0;
      r_ovf  <= 1'b0;
    end else begin
      case (r_mode)
        MODE_SUM: begin
          r_disp <= w_sum[POS_W-1:0];
          r_ovf  <= w_sum[POS_W];
        end
        MODE_DIFF: begin
          r_disp <= w_diff[POS_W-1:0];
          r_ovf  <= w_diff[POS_W];
        end
        MODE_LEFT: begin
          r_disp <= r_pos_l;
          r_ovf  <= 1'b0;
        end
        default: begin
          r_disp <= r_pos_r;
          r_ovf  <= 1'b0;
        end
      endcase
    end
  end

  assign pos_l     = r_pos_l;
  assign pos_r     = r_pos_r;
  assign disp_val  = r_disp;
  assign disp_mode = r_mode;
  assign disp_ovf  = r_ovf;
  assign click_evt = w_evt;

endmodule

// File: tb/tb_dial_sum_ctl.sv
// Scoreboard bench for dial_sum_ctl with DEBOUNCE_CYCLES=4.
module tb_dial_sum_ctl;

  localparam int K_POSL = 0;
  localparam int K_POSR = 1;
  localparam int K_DISP = 2;
  localparam int K_OVF  = 3;
  localparam int K_MODE = 4;
  localparam int K_CLK  = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rot_l_cw = 1'b0, rot_l_ccw = 1'b0, rot_r_cw = 1'b0, rot_r_ccw = 1'b0;
  logic       click_l_n = 1'b1, click_r_n = 1'b1;
  logic [7:0] pos_l, pos_r, disp_val;
  logic [1:0] disp_mode, click_evt;
  logic       disp_ovf;

  dial_sum_ctl #(.DEBOUNCE_CYCLES(4), .POS_RESET(8'h00)) dut (
    .clk(clk), .rst(rst),
    .rot_l_cw(rot_l_cw), .rot_l_ccw(rot_l_ccw),
    .rot_r_cw(rot_r_cw), .rot_r_ccw(rot_r_ccw),
    .click_l_n(click_l_n), .click_r_n(click_r_n),
    .pos_l(pos_l), .pos_r(pos_r), .disp_val(disp_val),
    .disp_mode(disp_mode), .disp_ovf(disp_ovf), .click_evt(click_evt)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int unsigned cyc; int kind; logic [7:0] val; } exp_t;
  typedef struct { int unsigned cyc; logic [1:0] val; } clk_exp_t;
  exp_t     expq[$];
  clk_exp_t clickq[$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic string kname(input int k);
    case (k)
      K_POSL:  return "pos_l";
      K_POSR:  return "pos_r";
      K_DISP:  return "disp_val";
      K_OVF:   return "disp_ovf";
      K_MODE:  return "disp_mode";
      default: return "click_evt";
    endcase
  endfunction

  function automatic logic [7:0] observe(input int k);
    case (k)
      K_POSL:  return pos_l;
      K_POSR:  return pos_r;
      K_DISP:  return disp_val;
      K_OVF:   return {7'd0, disp_ovf};
      K_MODE:  return {6'd0, disp_mode};
      default: return {6'd0, click_evt};
    endcase
  endfunction

  // Monitor: values scheduled for this cycle, plus every click pulse the DUT emits.
  always @(negedge clk) begin
    clk_exp_t c;
    for (int i = int'(expq.size()) - 1; i >= 0; i--) begin
      if (expq[i].cyc <= cyc) begin
        n_cmp++;
        if (expq[i].cyc < cyc) begin
          n_err++;
          $display("FAIL %s stale: due cyc %0d, now %0d", kname(expq[i].kind), expq[i].cyc, cyc);
        end else if (observe(expq[i].kind) !== expq[i].val) begin
          n_err++;
          $display("FAIL %s cyc=%0d got=%02h exp=%02h", kname(expq[i].kind), cyc,
                   observe(expq[i].kind), expq[i].val);
        end
        expq.delete(i);
      end
    end
    while (clickq.size() != 0 && clickq[0].cyc < cyc) begin
      c = clickq.pop_front();
      n_cmp++;
      n_err++;
      $display("FAIL click_missed exp=%b at cyc %0d, got nothing", c.val, c.cyc);
    end
    if (click_evt !== 2'b00) begin
      n_cmp++;
      if (clickq.size() == 0) begin
        n_err++;
        $display("FAIL click_unexpected cyc=%0d got=%b exp=00", cyc, click_evt);
      end else begin
        c = clickq.pop_front();
        if (c.val !== click_evt || c.cyc != cyc) begin
          n_err++;
          $display("FAIL click_evt got=%b@%0d exp=%b@%0d", click_evt, cyc, c.val, c.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int unsigned c, input int k, input logic [7:0] v);
    expq.push_back('{c, k, v});
  endtask

  task automatic rot(input logic lcw, input logic lccw, input logic rcw, input logic rccw);
    rot_l_cw = lcw; rot_l_ccw = lccw; rot_r_cw = rcw; rot_r_ccw = rccw;
    tick();
    rot_l_cw = 1'b0; rot_l_ccw = 1'b0; rot_r_cw = 1'b0; rot_r_ccw = 1'b0;
  endtask

  task automatic expect_reset_values(input int unsigned c);
    expect_at(c, K_POSL, 8'h00);
    expect_at(c, K_POSR, 8'h00);
    expect_at(c, K_DISP, 8'h00);
    expect_at(c, K_OVF,  8'h00);
    expect_at(c, K_MODE, 8'h00);
    expect_at(c, K_CLK,  8'h00);
  endtask

  task automatic click_r(input logic [1:0] m, input logic [7:0] dv, input logic ov);
    int unsigned s;
    click_r_n = 1'b0;
    s = cyc;
    clickq.push_back('{s + 4, 2'b10});
    expect_at(s + 5, K_MODE, {6'd0, m});
    expect_at(s + 6, K_DISP, dv);
    expect_at(s + 6, K_OVF,  {7'd0, ov});
    repeat (6) tick();
    click_r_n = 1'b1;
    repeat (6) tick();
  endtask

  task automatic click_l();
    int unsigned s;
    click_l_n = 1'b0;
    s = cyc;
    clickq.push_back('{s + 4, 2'b01});
    expect_at(s + 5, K_POSL, 8'h00);
    expect_at(s + 5, K_POSR, 8'h00);
    repeat (6) tick();
    click_l_n = 1'b1;
    repeat (6) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned s;
    repeat (3) tick();
    rst = 1'b0;
    expect_reset_values(cyc);
    tick();

    // 3 left cw, 1 right ccw: 03 + FF = 102
    rot(1, 0, 0, 0);
    rot(1, 0, 0, 0);
    rot(1, 0, 0, 1);
    expect_at(cyc, K_POSL, 8'h03);
`ifdef DIAL_SATURATE_EN
    expect_at(cyc, K_POSR, 8'h00);
    expect_at(cyc + 1, K_DISP, 8'h03);
    expect_at(cyc + 1, K_OVF, 8'h00);
`else
    expect_at(cyc, K_POSR, 8'hFF);
    expect_at(cyc + 1, K_DISP, 8'h02);
    expect_at(cyc + 1, K_OVF, 8'h01);
`endif
    tick();

    rot(0, 0, 1, 1);
`ifdef DIAL_SATURATE_EN
    expect_at(cyc, K_POSR, 8'h00);
`else
    expect_at(cyc, K_POSR, 8'hFF);
`endif
    // Left click event coinciding with a left cw pulse: clear wins.
    click_l_n = 1'b0;
    s = cyc;
    clickq.push_back('{s + 4, 2'b01});
    repeat (4) tick();
    rot(1, 0, 0, 0);
    expect_at(cyc, K_POSL, 8'h00);
    expect_at(cyc, K_POSR, 8'h00);
    expect_at(cyc + 1, K_DISP, 8'h00);
    click_l_n = 1'b1;
    repeat (6) tick();

    // 3-cycle glitch on the right click must be ignored.
    click_r_n = 1'b0;
    repeat (3) tick();
    click_r_n = 1'b1;
    repeat (6) tick();
    expect_at(cyc, K_MODE, 8'h00);

    repeat (5) rot(1, 0, 1, 0);
    repeat (2) rot(0, 0, 1, 0);
    expect_at(cyc, K_POSL, 8'h05);
    expect_at(cyc, K_POSR, 8'h07);
    expect_at(cyc + 1, K_DISP, 8'h0C);
    expect_at(cyc + 1, K_OVF, 8'h00);
    tick();
    click_r(2'd1, 8'hFE, 1'b1);

    click_r(2'd2, 8'h05, 1'b0);
    repeat (160) rot(1, 0, 0, 0);
    expect_at(cyc, K_POSL, 8'hA5);
    expect_at(cyc + 1, K_DISP, 8'hA5);
    expect_at(cyc + 1, K_OVF, 8'h00);
    tick();
    click_r(2'd3, 8'h07, 1'b0);
    click_r(2'd0, 8'hAC, 1'b0);
    click_r(2'd1, 8'h9E, 1'b0);

    // Position boundaries, display in MODE_DIFF.
    click_l();
`ifdef DIAL_SATURATE_EN
    rot(0, 1, 0, 0);
    expect_at(cyc, K_POSL, 8'h00);
    repeat (255) rot(1, 0, 0, 0);
    expect_at(cyc, K_POSL, 8'hFF);
    rot(1, 0, 0, 0);
    expect_at(cyc, K_POSL, 8'hFF);
    rot(0, 0, 1, 0);
    expect_at(cyc, K_POSR, 8'h01);
    expect_at(cyc + 1, K_DISP, 8'hFE);
    expect_at(cyc + 1, K_OVF, 8'h00);
`else
    rot(0, 1, 0, 0);
    expect_at(cyc, K_POSL, 8'hFF);
    expect_at(cyc + 1, K_DISP, 8'hFF);
    expect_at(cyc + 1, K_OVF, 8'h00);
    tick();
    rot(1, 0, 0, 0);
    expect_at(cyc, K_POSL, 8'h00);
    rot(0, 0, 1, 0);
    expect_at(cyc, K_POSR, 8'h01);
    expect_at(cyc + 1, K_DISP, 8'hFF);
    expect_at(cyc + 1, K_OVF, 8'h01);
`endif
    tick();

    // Reset mid-debounce with the right button held through release.
    click_r_n = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    expect_reset_values(cyc);
    repeat (2) tick();
    rst = 1'b0;
    s = cyc;
    expect_at(s, K_MODE, 8'h00);
    expect_at(s + 3, K_MODE, 8'h00);
    clickq.push_back('{s + 4, 2'b10});
    expect_at(s + 5, K_MODE, 8'h01);
    repeat (6) tick();
    click_r_n = 1'b1;
    repeat (8) tick();

    n_cmp++;
    if (expq.size() != 0 || clickq.size() != 0) begin
      n_err++;
      $display("FAIL drain: pending values=%0d clicks=%0d, expected 0/0", expq.size(), clickq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
